// File: rtl/ex_mem_cond_stage_if.sv
// Execute-to-memory stage bus: E-stage instruction fields, pipeline control,
// and the registered M-stage outputs with architectural flags and retire count.
interface ex_mem_cond_stage_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
);
  logic              stall;
  logic              flush;
  logic              valid_e;
  logic [2:0]        cond_e;
  logic              flag_write_e;
  logic              reg_write_e;
  logic              mem_write_e;
  logic              mem_to_reg_e;
  logic              branch_e;
  logic [DATA_W-1:0] alu_result_e;
  logic [3:0]        alu_flags_e;
  logic [DATA_W-1:0] write_data_e;
  logic [RD_W-1:0]   rd_e;
  logic              cond_pass_e;
  logic              branch_taken_e;
  logic              valid_m;
  logic              reg_write_m;
  logic              mem_write_m;
  logic              mem_to_reg_m;
  logic [DATA_W-1:0] alu_result_m;
  logic [DATA_W-1:0] write_data_m;
  logic [RD_W-1:0]   rd_m;
  logic [3:0]        flags_q;
  logic [DATA_W-1:0] retired_count;

  // Pipeline handshake: an E-stage instruction moves into M on a rising edge
  // only when flush and stall are both low; flush inserts a bubble and wins
  // over stall; stall holds every M-stage output, the flags and the counter.
  modport slave (
    input  stall, flush, valid_e, cond_e, flag_write_e, reg_write_e,
           mem_write_e, mem_to_reg_e, branch_e, alu_result_e, alu_flags_e,
           write_data_e, rd_e,
    output cond_pass_e, branch_taken_e, valid_m, reg_write_m, mem_write_m,
           mem_to_reg_m, alu_result_m, write_data_m, rd_m, flags_q,
           retired_count
  );

  modport master (
    output stall, flush, valid_e, cond_e, flag_write_e, reg_write_e,
           mem_write_e, mem_to_reg_e, branch_e, alu_result_e, alu_flags_e,
           write_data_e, rd_e,
    input  cond_pass_e, branch_taken_e, valid_m, reg_write_m, mem_write_m,
           mem_to_reg_m, alu_result_m, write_data_m, rd_m, flags_q,
           retired_count
  );
endinterface

// File: rtl/ex_mem_cond_stage.sv
// E->M pipeline register with NZCV flags, condition evaluation against the
// current flags, branch redirect request and retired-instruction counter.
module ex_mem_cond_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ex_mem_cond_stage_if.slave   bus
);
  logic cond_true;
  logic advance;
  logic flag_n, flag_z, flag_v;

  assign flag_n = bus.flags_q[3];
  assign flag_z = bus.flags_q[2];
  assign flag_v = bus.flags_q[0];

  always_comb begin
    cond_true = 1'b0;
    case (bus.cond_e)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = !flag_z;
      3'b011:  cond_true = (flag_n != flag_v);
      3'b100:  cond_true = (flag_n == flag_v);
      3'b101:  cond_true = !flag_z && (flag_n == flag_v);
      3'b110:  cond_true = flag_z || (flag_n != flag_v);
      default: cond_true = 1'b0;
    endcase
  end

  assign advance            = !bus.flush && !bus.stall;
  assign bus.cond_pass_e    = bus.valid_e && cond_true;
  // Flush is generated from this redirect, so it must not gate it.
  assign bus.branch_taken_e = bus.cond_pass_e && bus.branch_e && !bus.stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_m      <= 1'b0;
      bus.reg_write_m  <= 1'b0;
      bus.mem_write_m  <= 1'b0;
      bus.mem_to_reg_m <= 1'b0;
      bus.alu_result_m <= '0;
      bus.write_data_m <= '0;
      bus.rd_m         <= '0;
    end else if (bus.flush) begin
      bus.valid_m      <= 1'b0;
      bus.reg_write_m  <= 1'b0;
      bus.mem_write_m  <= 1'b0;
      bus.mem_to_reg_m <= 1'b0;
    end else if (!bus.stall) begin
      // Failed conditions still occupy the slot but lose their side effects.
      bus.valid_m      <= bus.valid_e;
      bus.reg_write_m  <= bus.reg_write_e && bus.cond_pass_e;
      bus.mem_write_m  <= bus.mem_write_e && bus.cond_pass_e;
      bus.mem_to_reg_m <= bus.mem_to_reg_e && bus.cond_pass_e;
      bus.alu_result_m <= bus.alu_result_e;
      bus.write_data_m <= bus.write_data_e;
      bus.rd_m         <= bus.rd_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.flags_q       <= 4'b0000;
      bus.retired_count <= '0;
    end else if (advance && bus.cond_pass_e) begin
      if (bus.flag_write_e) bus.flags_q <= bus.alu_flags_e;
      bus.retired_count <= bus.retired_count + DATA_W'(1);
    end
  end
endmodule
